// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared types and defaults for the multiplier scheduler.
// Contents: state_t FSM encoding, gnt_t requester index (up to 4 requesters),
// DEF_WIDTH/DEF_NREQ default parameters.
package mul_sched_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREQ  = 2;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ACCUM, DONE} state_t;
    typedef logic [1:0] gnt_t;
endpackage

// File: rtl/mul_sched_ctrl_if.sv
// mul_sched_ctrl_if: controller-to-datapath bus of the repeated-addition multiplier.
// master (controller): drives dp_bus, ld_a, ld_b, ld_p, clr_p, dec_b; reads eqz, dp_p.
// slave  (datapath)  : the mirror image.
interface mul_sched_ctrl_if #(parameter int WIDTH = mul_sched_pkg::DEF_WIDTH);
    logic [WIDTH-1:0] dp_bus;
    logic [WIDTH-1:0] dp_p;
    logic             ld_a, ld_b, ld_p, clr_p, dec_b, eqz;
    modport master (output dp_bus, ld_a, ld_b, ld_p, clr_p, dec_b, input eqz, dp_p);
    modport slave  (input dp_bus, ld_a, ld_b, ld_p, clr_p, dec_b, output eqz, dp_p);
endinterface

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
// Ports: req (request vector), ptr (highest-priority index), vld (any request), idx (winner).
module mul_rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] req,
    input  gnt_t            ptr,
    output logic            vld,
    output gnt_t            idx
);
    always_comb begin
        vld = |req;
        idx = '0;
        // Scan from farthest to nearest offset so the nearest request wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) idx = gnt_t'((int'(ptr) + i) % NREQ);
        end
    end
endmodule

// File: rtl/mul_sched_ctrl.sv
// mul_sched_ctrl: round-robin scheduler sharing one repeated-addition multiplier datapath.
// Ports: clk, rst_n (sync active-low); req/req_a/req_b per requester; ack one-cycle pulse
// with rsp_data product; busy outside IDLE; dp master modport to the datapath.
// Optional: MUL_ZERO_BYPASS_EN answers zero operands directly from IDLE.
module mul_sched_ctrl
    import mul_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy,
    mul_sched_ctrl_if.master      dp
);
    state_t state_q, state_d;
    gnt_t gnt_q, gnt_d, ptr_q, ptr_d, arb_idx, sel;
    logic arb_vld;
    logic [WIDTH-1:0] op_a, op_b;
`ifdef MUL_ZERO_BYPASS_EN
    logic byp_q, byp_d;
`endif

    mul_rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req), .ptr(ptr_q), .vld(arb_vld), .idx(arb_idx));

    // In IDLE the operands of the would-be winner are needed for the zero bypass.
    assign sel  = (state_q == IDLE) ? arb_idx : gnt_q;
    assign op_a = req_a[int'(sel)*WIDTH +: WIDTH];
    assign op_b = req_b[int'(sel)*WIDTH +: WIDTH];
    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        ack       = '0;
        rsp_data  = '0;
        dp.dp_bus = '0;
        dp.ld_a   = 1'b0;
        dp.ld_b   = 1'b0;
        dp.ld_p   = 1'b0;
        dp.clr_p  = 1'b0;
        dp.dec_b  = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
        byp_d     = byp_q;
`endif
        case (state_q)
            IDLE: if (arb_vld) begin
                gnt_d   = arb_idx;
                state_d = LOAD_A;
`ifdef MUL_ZERO_BYPASS_EN
                byp_d   = (op_a == '0) || (op_b == '0);
                state_d = byp_d ? DONE : LOAD_A;
`endif
            end
            LOAD_A: begin
                dp.dp_bus = op_a;
                dp.ld_a   = 1'b1;
                state_d   = LOAD_B;
            end
            LOAD_B: begin
                dp.dp_bus = op_b;
                dp.ld_b   = 1'b1;
                dp.clr_p  = 1'b1;
                state_d   = ACCUM;
            end
            ACCUM: begin
                dp.ld_p  = !dp.eqz;
                dp.dec_b = !dp.eqz;
                state_d  = dp.eqz ? DONE : ACCUM;
            end
            DONE: begin
                ack      = NREQ'(1) << gnt_q;
`ifdef MUL_ZERO_BYPASS_EN
                rsp_data = byp_q ? '0 : dp.dp_p;
`else
                rsp_data = dp.dp_p;
`endif
                ptr_d    = gnt_t'((int'(gnt_q) + 1) % NREQ);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
`ifdef MUL_ZERO_BYPASS_EN
            byp_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
`ifdef MUL_ZERO_BYPASS_EN
            byp_q   <= byp_d;
`endif
        end
    end
endmodule

// File: tb/tb_mul_sched_ctrl.sv
// tb_mul_sched_ctrl: directed self-checking bench with a behavioural multiplier datapath.
module tb_mul_sched_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [1:0]  ack;
    logic [15:0] rsp_data;
    logic        busy;
    logic [15:0] ra, rb, rp;
    int checks = 0;
    int failures = 0;
    int n_ldp = 0, n_decb = 0, n_clrp = 0, n_strb = 0;
    int n, s_ldp, s_decb, s_clrp, s_strb;

    mul_sched_ctrl_if #(.WIDTH(16)) dp_if ();

    mul_sched_ctrl #(.WIDTH(16), .NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .ack(ack), .rsp_data(rsp_data), .busy(busy), .dp(dp_if.master)
    );

    always #5 clk = ~clk;

    // Reference datapath: A, B, P registers with B==0 flag.
    initial begin
        ra = '0;
        rb = '0;
        rp = '0;
    end
    assign dp_if.eqz  = (rb == 16'd0);
    assign dp_if.dp_p = rp;
    always @(posedge clk) begin
        if (dp_if.ld_a) ra <= dp_if.dp_bus;
        if (dp_if.ld_b) rb <= dp_if.dp_bus;
        else if (dp_if.dec_b) rb <= rb - 16'd1;
        if (dp_if.clr_p) rp <= '0;
        else if (dp_if.ld_p) rp <= rp + ra;
        n_ldp  <= n_ldp + int'(dp_if.ld_p);
        n_decb <= n_decb + int'(dp_if.dec_b);
        n_clrp <= n_clrp + int'(dp_if.clr_p);
        n_strb <= n_strb + int'(dp_if.ld_a | dp_if.ld_b | dp_if.ld_p | dp_if.clr_p | dp_if.dec_b);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_ldp = n_ldp;
        s_decb = n_decb;
        s_clrp = n_clrp;
        s_strb = n_strb;
    endtask

    task automatic wait_ack(input int limit, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (ack == 2'b00 && cnt < limit);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req[i] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single request: drive at negedge, count posedges to ack, then release.
    task automatic run_op(input string tag, input int i, input logic [15:0] a,
                          input logic [15:0] b, input int exp_n, input logic [15:0] exp_p);
        @(negedge clk);
        set_op(i, a, b);
        snap();
        wait_ack(60, n);
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_ack"}, ack, 2'b01 << i);
        chk({tag, "_data"}, rsp_data, exp_p);
        @(negedge clk);
        req[i] = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {ack, rsp_data, busy, dp_if.dp_bus}, '0);
        chk("rst_strb", {dp_if.ld_a, dp_if.ld_b, dp_if.ld_p, dp_if.clr_p, dp_if.dec_b}, '0);
        rst_n = 1'b1;

        run_op("m17x5", 0, 16'd17, 16'd5, 9, 16'd85);
        chk("m17x5_ldp", n_ldp - s_ldp, 5);
        chk("m17x5_decb", n_decb - s_decb, 5);
        chk("m17x5_clrp", n_clrp - s_clrp, 1);

`ifdef MUL_ZERO_BYPASS_EN
        run_op("b0", 0, 16'd9, 16'd0, 1, 16'd0);
        chk("b0_strb", n_strb - s_strb, 0);
`else
        run_op("b0", 0, 16'd9, 16'd0, 4, 16'd0);
        chk("b0_ldp", n_ldp - s_ldp, 0);
`endif

        run_op("ovf", 0, 16'h8000, 16'd3, 7, 16'h8000);

        // Contention from reset: r0, then r1, then r0 again with both held.
        do_reset();
        @(negedge clk);
        set_op(0, 16'd3, 16'd4);
        set_op(1, 16'd6, 16'd2);
        wait_ack(60, n);
        chk("rr1_lat", n, 8);
        chk("rr1_ack", ack, 2'b01);
        chk("rr1_data", rsp_data, 16'd12);
        wait_ack(60, n);
        chk("rr2_lat", n, 7);
        chk("rr2_ack", ack, 2'b10);
        chk("rr2_data", rsp_data, 16'd12);
        wait_ack(60, n);
        chk("rr3_lat", n, 9);
        chk("rr3_ack", ack, 2'b01);
        chk("rr3_data", rsp_data, 16'd12);
        @(negedge clk);
        req = '0;

        // Reset while accumulating: outputs clear, no late ack.
        @(negedge clk);
        set_op(0, 16'd2, 16'd9);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        @(posedge clk);
        #1;
        chk("mrst_outs", {ack, rsp_data, busy, dp_if.dp_bus}, '0);
        chk("mrst_strb", {dp_if.ld_a, dp_if.ld_b, dp_if.ld_p, dp_if.clr_p, dp_if.dec_b}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(15, n);
        chk("mrst_noack", {30'd0, ack}, 0);
        run_op("m2x3", 0, 16'd2, 16'd3, 7, 16'd6);

        // r1 held: back-to-back grants with one IDLE cycle between.
        @(negedge clk);
        set_op(1, 16'd4, 16'd3);
        wait_ack(60, n);
        chk("bb1_lat", n, 7);
        chk("bb1_ack", ack, 2'b10);
        chk("bb1_data", rsp_data, 16'd12);
        @(posedge clk);
        #1;
        chk("bb_idle", {busy, dp_if.ld_a}, 2'b00);
        @(posedge clk);
        #1;
        chk("bb_lda", {dp_if.ld_a, dp_if.dp_bus}, {1'b1, 16'd4});
        @(posedge clk);
        #1;
        chk("bb_ldb", {dp_if.ld_b, dp_if.clr_p, dp_if.dp_bus}, {2'b11, 16'd3});
        wait_ack(60, n);
        chk("bb2_lat", n, 5);
        chk("bb2_ack", ack, 2'b10);
        chk("bb2_data", rsp_data, 16'd12);
        @(negedge clk);
        req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
